// File: rtl/gmii_rx_parse.sv
// GMII receive parser: strips preamble, Ethernet and stream headers and feeds video/audio FIFOs.
// Optional FCS checking is compiled in with `define GMII_RX_CRC_EN.
module gmii_rx_parse #(
  parameter logic [47:0] MAC_ADDR  = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [7:0]  ID        = 8'h01
) (
  input  logic        rx_clk,
  input  logic        rstbtn_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic [47:0] vid_din,
  output logic        vid_wr_en,
  input  logic        vid_full,
  output logic [11:0] aud_din,
  output logic        aud_wr_en,
  input  logic        aud_full,
  output logic [10:0] line_num,
  output logic [3:0]  ade_num,
  output logic        hdr_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  localparam int unsigned DLY     = 4;
  localparam logic [7:0]  B_PRE   = 8'h55;
  localparam logic [7:0]  B_SFD   = 8'hD5;
  localparam logic [7:0]  T_VID   = 8'h01;
  localparam logic [7:0]  T_AUD   = 8'h02;
  localparam logic [3:0]  ETH_END = 4'd13;
  localparam logic [3:0]  HDR_END = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ETH, S_SHDR, S_VID, S_AUD, S_PAD, S_DROP
  } state_t;

  state_t state, state_nx;

  logic                    dv0, er0;
  logic [7:0]              d0;
  logic [DLY-1:0]          dv_sr, er_sr;
  logic [DLY-1:0][7:0]     dat_sr;
  logic                    armed;

  logic [3:0]  idx;
  logic [2:0]  wb;
  logic [15:0] wcnt;
  logic        mac_hit, bc_hit, is_aud, err_q;
  logic [3:0]  ade_q;
  logic [2:0]  lhi_q;
  logic [7:0]  l0_q, c1_q;
  logic [39:0] word_sr;

  logic       byte_ok, at_end, in_frame;
  logic [7:0] cur, mac_byte_c;
  logic       mac_ok_c, crc_bad_c;
  logic       hdr_valid_c, vid_word_c, aud_word_c, frame_done_c, frame_err_c;

  // Input register plus 4-byte delay line; a byte is decodable only if 4 more frame bytes follow it
  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      dv0    <= 1'b0;
      er0    <= 1'b0;
      d0     <= '0;
      dv_sr  <= '0;
      er_sr  <= '0;
      dat_sr <= '0;
      armed  <= 1'b0;
    end else begin
      dv0    <= rx_dv;
      er0    <= rx_er;
      d0     <= rxd;
      dv_sr  <= {dv_sr[DLY-2:0], dv0};
      er_sr  <= {er_sr[DLY-2:0], er0};
      dat_sr <= {dat_sr[DLY-2:0], d0};
      armed  <= armed | ~rx_dv;
    end
  end

  assign cur      = dat_sr[DLY-1];
  assign byte_ok  = dv0 & (&dv_sr);
  assign at_end   = ~dv_sr[DLY-1];
  assign in_frame = (state == S_SHDR) || (state == S_VID) || (state == S_AUD) || (state == S_PAD);

  always_comb begin
    mac_byte_c = 8'h00;
    case (idx)
      4'd0:    mac_byte_c = MAC_ADDR[47:40];
      4'd1:    mac_byte_c = MAC_ADDR[39:32];
      4'd2:    mac_byte_c = MAC_ADDR[31:24];
      4'd3:    mac_byte_c = MAC_ADDR[23:16];
      4'd4:    mac_byte_c = MAC_ADDR[15:8];
      4'd5:    mac_byte_c = MAC_ADDR[7:0];
      default: mac_byte_c = 8'h00;
    endcase
  end

  assign mac_ok_c = (mac_hit && (cur == mac_byte_c)) || (bc_hit && (cur == 8'hFF));

  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (armed && byte_ok && (cur == B_PRE)) state_nx = S_PRE;
      S_PRE: begin
        if (at_end) state_nx = S_IDLE;
        else if (byte_ok) begin
          if (cur == B_SFD)      state_nx = S_ETH;
          else if (cur != B_PRE) state_nx = S_DROP;
        end
      end
      S_ETH: begin
        if (at_end) state_nx = S_IDLE;
        else if (byte_ok) begin
          if (((idx == 4'd5) && !mac_ok_c) ||
              ((idx == 4'd12) && (cur != ETHERTYPE[15:8])) ||
              ((idx == ETH_END) && (cur != ETHERTYPE[7:0])))
            state_nx = S_DROP;
          else if (idx == ETH_END)
            state_nx = S_SHDR;
        end
      end
      S_SHDR: begin
        if (at_end) state_nx = S_IDLE;
        else if (byte_ok) begin
          if (((idx == 4'd0) && (cur != T_VID) && (cur != T_AUD)) ||
              ((idx == 4'd1) && (cur != ID)))
            state_nx = S_DROP;
          else if (idx == HDR_END) begin
            if ({c1_q, cur} == 16'd0) state_nx = S_PAD;
            else if (is_aud)          state_nx = S_AUD;
            else                      state_nx = S_VID;
          end
        end
      end
      S_VID: begin
        if (at_end) state_nx = S_IDLE;
        else if (byte_ok && (wb == 3'd5) && (wcnt == 16'd1)) state_nx = S_PAD;
      end
      S_AUD: begin
        if (at_end) state_nx = S_IDLE;
        else if (byte_ok && (wb == 3'd1) && (wcnt == 16'd1)) state_nx = S_PAD;
      end
      S_PAD, S_DROP: if (at_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Leaving early from VID/AUD means the word count was not exhausted
  always_comb begin
    hdr_valid_c  = (state == S_SHDR) && byte_ok && (idx == HDR_END);
    vid_word_c   = (state == S_VID) && byte_ok && (wb == 3'd5);
    aud_word_c   = (state == S_AUD) && byte_ok && (wb == 3'd1);
    frame_done_c = at_end && ((state == S_VID) || (state == S_AUD) || (state == S_PAD));
    frame_err_c  = err_q || (state != S_PAD) || crc_bad_c;
  end

  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      idx        <= '0;
      wb         <= '0;
      wcnt       <= '0;
      mac_hit    <= 1'b0;
      bc_hit     <= 1'b0;
      is_aud     <= 1'b0;
      err_q      <= 1'b0;
      ade_q      <= '0;
      lhi_q      <= '0;
      l0_q       <= '0;
      c1_q       <= '0;
      word_sr    <= '0;
      vid_din    <= '0;
      vid_wr_en  <= 1'b0;
      aud_din    <= '0;
      aud_wr_en  <= 1'b0;
      line_num   <= '0;
      ade_num    <= '0;
      hdr_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      vid_wr_en  <= 1'b0;
      aud_wr_en  <= 1'b0;
      hdr_valid  <= hdr_valid_c;
      frame_done <= frame_done_c;
      frame_err  <= frame_done_c && frame_err_c;
      case (state)
        S_PRE: if (byte_ok && (cur == B_SFD)) begin
          idx     <= '0;
          mac_hit <= 1'b1;
          bc_hit  <= 1'b1;
          err_q   <= 1'b0;
        end
        S_ETH: if (byte_ok) begin
          idx <= (idx == ETH_END) ? 4'd0 : 4'(idx + 4'd1);
          if (idx < 4'd6) begin
            mac_hit <= mac_hit && (cur == mac_byte_c);
            bc_hit  <= bc_hit && (cur == 8'hFF);
          end
        end
        S_SHDR: if (byte_ok) begin
          idx <= 4'(idx + 4'd1);
          case (idx)
            4'd0: is_aud <= (cur == T_AUD);
            4'd2: begin
              ade_q <= cur[7:4];
              lhi_q <= cur[2:0];
            end
            4'd3: l0_q <= cur;
            4'd4: c1_q <= cur;
            4'd5: begin
              wcnt     <= {c1_q, cur};
              wb       <= '0;
              line_num <= {lhi_q, l0_q};
              if (is_aud) ade_num <= ade_q;
            end
            default: ;
          endcase
        end
        S_VID, S_AUD: if (byte_ok) begin
          word_sr <= {word_sr[31:0], cur};
          if (vid_word_c || aud_word_c) begin
            wb   <= '0;
            wcnt <= 16'(wcnt - 16'd1);
            if ((vid_word_c && vid_full) || (aud_word_c && aud_full)) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= 16'(drop_cnt + 16'd1);
            end else if (vid_word_c) begin
              vid_din   <= {word_sr, cur};
              vid_wr_en <= 1'b1;
            end else begin
              aud_din   <= {word_sr[3:0], cur};
              aud_wr_en <= 1'b1;
            end
          end else begin
            wb <= 3'(wb + 3'd1);
          end
        end
        default: ;
      endcase
      if (in_frame && dv_sr[DLY-1] && er_sr[DLY-1]) err_q <= 1'b1;
    end
  end

`ifdef GMII_RX_CRC_EN
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q, crc_nx_c, crc_rev_c;

  // Reflected CRC-32, one byte per cycle; compared bit-reversed against the residue
  always_comb begin
    crc_nx_c = crc_q ^ {24'd0, cur};
    for (int i = 0; i < 8; i++)
      crc_nx_c = crc_nx_c[0] ? ((crc_nx_c >> 1) ^ CRC_POLY_R) : (crc_nx_c >> 1);
    crc_rev_c = '0;
    for (int i = 0; i < 32; i++) crc_rev_c[i] = crc_q[31-i];
    crc_bad_c = (crc_rev_c != CRC_RESIDUE);
  end

  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n)
      crc_q <= '1;
    else if ((state == S_PRE) && byte_ok && (cur == B_SFD))
      crc_q <= '1;
    else if (dv_sr[DLY-1] && ((state == S_ETH) || in_frame))
      crc_q <= crc_nx_c;
  end
`else
  assign crc_bad_c = 1'b0;
`endif

endmodule
